// File: rtl/aemb2_iwbm.sv
// rtl/aemb2_iwbm.sv - AEMB2 instruction Wishbone master and critical-word-first line refill engine
module aemb2_iwbm #(
  parameter int AEMB_IWB = 32,
  parameter int AEMB_IDX = 6
) (
  input  logic                gclk,
  input  logic                grst,
  input  logic                ich_req,
  input  logic [AEMB_IWB-1:2] ich_adr,
  input  logic                ich_hit,
  input  logic                iwb_ack_i,
  output logic [AEMB_IWB-1:2] iwb_adr_o,
  output logic                iwb_cyc_o,
  output logic                iwb_stb_o,
  output logic [3:0]          iwb_sel_o,
  output logic                iwb_wre_o,
  output logic [2:0]          iwb_cti_o,
  output logic [1:0]          iwb_bte_o,
  output logic                ich_fill,
  output logic                ich_stall
);

  localparam int LNE = AEMB_IDX - 2;
  localparam int VAL = 1 << LNE;
  localparam int AW  = AEMB_IWB - 2;
  localparam int CW  = LNE + 1;

  // Low address bits that wrap inside the cache line; the rest is the line base.
  localparam logic [AW-1:0] OFS_MASK  = AW'(VAL - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(VAL - 1);
  localparam logic [1:0]    BTE       = (LNE == 2) ? 2'b01 :
                                        (LNE == 3) ? 2'b10 :
                                        (LNE == 4) ? 2'b11 : 2'b00;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {IDLE, FILL, SETTLE} stateT;

  stateT          state, nextState;
  logic [AW-1:0]  adrReg, adrNext;
  logic [CW-1:0]  count, cntNext, cntPlus;
  logic [2:0]     ctiReg, ctiNext;
  logic           cycReg, cycNext;
  logic           miss, beatAck, lastAck;

  assign miss    = ich_req & ~ich_hit;
  assign beatAck = (state == FILL) & iwb_ack_i;
  assign lastAck = beatAck & (count == LAST_BEAT);
  assign cntPlus = count + CW'(1);

  // State register plus the registered bus-side outputs.
  always_ff @(posedge gclk) begin
    if (grst) begin
      state  <= IDLE;
      adrReg <= '0;
      count  <= '0;
      ctiReg <= CTI_CLASSIC;
      cycReg <= 1'b0;
    end else begin
      state  <= nextState;
      adrReg <= adrNext;
      count  <= cntNext;
      ctiReg <= ctiNext;
      cycReg <= cycNext;
    end
  end

  // Next state: a miss starts a fill, the final ack ends it, settle lasts one cycle.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (miss) nextState = FILL;
      FILL:    if (lastAck) nextState = SETTLE;
      SETTLE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Next values of the registered outputs; the offset wraps inside the line on each ack.
  always_comb begin
    adrNext = adrReg;
    cntNext = count;
    ctiNext = ctiReg;
    cycNext = cycReg;
    case (state)
      IDLE: begin
        if (miss) begin
          adrNext = ich_adr;
          cntNext = '0;
          cycNext = 1'b1;
          ctiNext = (LAST_BEAT == CW'(0)) ? CTI_END : CTI_INCR;
        end
      end
      FILL: begin
        if (beatAck) begin
          adrNext = (adrReg & ~OFS_MASK) | ((adrReg + AW'(1)) & OFS_MASK);
          cntNext = cntPlus;
          if (lastAck) begin
            cycNext = 1'b0;
            ctiNext = CTI_CLASSIC;
          end else begin
            ctiNext = (cntPlus == LAST_BEAT) ? CTI_END : CTI_INCR;
          end
        end
      end
      default: begin
        cycNext = 1'b0;
        ctiNext = CTI_CLASSIC;
      end
    endcase
  end

  assign iwb_adr_o = adrReg;
  assign iwb_cyc_o = cycReg;
  assign iwb_stb_o = cycReg;
  assign iwb_cti_o = ctiReg;
  assign iwb_sel_o = 4'hF;
  assign iwb_wre_o = 1'b0;
  assign iwb_bte_o = BTE;

  // The miss cycle itself must stall, so the request term is combinational.
  assign ich_fill  = (state == FILL);
  assign ich_stall = (state != IDLE) | miss;

endmodule

// File: tb/tb_aemb2_iwbm.sv
// tb/tb_aemb2_iwbm.sv - scoreboard bench for the instruction refill engine
module tb_aemb2_iwbm;

  localparam int VAL = 16;

  logic        gclk = 1'b0;
  logic        grst;
  logic        req, hit, ack;
  logic [31:2] adr;
  logic [31:2] adrO;
  logic        cyc, stb, wre, fill, stall;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;

  logic        req2, hit2, ack2;
  logic [31:2] adr2;
  logic [31:2] adrO2;
  logic        cyc2, stb2, wre2, fill2, stall2;
  logic [3:0]  sel2;
  logic [2:0]  cti2;
  logic [1:0]  bte2;

  int tests = 0;
  int fails = 0;
  int cycNum = 0;

  logic [29:0] expA[$];
  logic [2:0]  expC[$];

  aemb2_iwbm #(.AEMB_IWB(32), .AEMB_IDX(6)) dut (
    .gclk(gclk), .grst(grst), .ich_req(req), .ich_adr(adr), .ich_hit(hit),
    .iwb_ack_i(ack), .iwb_adr_o(adrO), .iwb_cyc_o(cyc), .iwb_stb_o(stb),
    .iwb_sel_o(sel), .iwb_wre_o(wre), .iwb_cti_o(cti), .iwb_bte_o(bte),
    .ich_fill(fill), .ich_stall(stall)
  );

  aemb2_iwbm #(.AEMB_IWB(32), .AEMB_IDX(2)) dut2 (
    .gclk(gclk), .grst(grst), .ich_req(req2), .ich_adr(adr2), .ich_hit(hit2),
    .iwb_ack_i(ack2), .iwb_adr_o(adrO2), .iwb_cyc_o(cyc2), .iwb_stb_o(stb2),
    .iwb_sel_o(sel2), .iwb_wre_o(wre2), .iwb_cti_o(cti2), .iwb_bte_o(bte2),
    .ich_fill(fill2), .ich_stall(stall2)
  );

  always #5 gclk = ~gclk;
  always @(posedge gclk) cycNum++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge gclk);
    #1;
  endtask

  // Monitor: every bus cycle must present the front of the expected beat list.
  always @(negedge gclk) begin
    if (cyc === 1'b1) begin
      if (expA.size() == 0) begin
        chk("unexpected cyc", {31'd0, cyc}, 32'd0);
      end else begin
        chk("beat adr", {2'b00, adrO}, {2'b00, expA[0]});
        chk("beat cti", {29'd0, cti}, {29'd0, expC[0]});
        chk("beat stb", {31'd0, stb}, 32'd1);
        chk("beat fill", {31'd0, fill}, 32'd1);
        if (ack === 1'b1) begin
          void'(expA.pop_front());
          void'(expC.pop_front());
        end
      end
    end
  end

  // One miss and its refill; w < 0 picks 0..2 wait states per beat at random,
  // rstBeat >= 0 asserts reset while that beat is on the bus.
  task automatic doFill(input logic [29:0] word, input int w, input int rstBeat);
    int n0, waits, total;
    logic [29:0] base;
    base = word - (word % VAL);
    for (int k = 0; k < VAL; k++) begin
      expA.push_back(base + ((word % VAL + k) % VAL));
      expC.push_back((k == VAL - 1) ? 3'b111 : 3'b010);
    end
    req = 1'b1; hit = 1'b0; adr = word; ack = 1'b0;
    n0 = cycNum;
    #1 chk("miss-cycle stall", {31'd0, stall}, 32'd1);
    tick;
    hit = 1'b1;
    total = 0;
    for (int k = 0; k < VAL; k++) begin
      waits = (w < 0) ? int'($urandom_range(0, 2)) : w;
      if (k == rstBeat) begin
        grst = 1'b1; ack = 1'b0;
        tick;
        chk("reset cyc drop", {31'd0, cyc}, 32'd0);
        chk("reset stb drop", {31'd0, stb}, 32'd0);
        chk("reset fill drop", {31'd0, fill}, 32'd0);
        expA.delete(); expC.delete();
        grst = 1'b0; req = 1'b0; hit = 1'b0;
        tick;
        return;
      end
      repeat (waits) begin ack = 1'b0; tick; end
      ack = 1'b1;
      tick;
      ack = 1'b0;
      total += waits;
    end
    chk("settle cyc", {31'd0, cyc}, 32'd0);
    chk("settle fill", {31'd0, fill}, 32'd0);
    chk("settle stall", {31'd0, stall}, 32'd1);
    chk("beats left", expA.size(), 32'd0);
    for (int i = 0; i < 20 && stall !== 1'b0; i++) tick;
    chk("release latency", cycNum - n0, VAL + 2 + total);
    req = 1'b0; hit = 1'b0;
    tick;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    logic [29:0] w2;
    grst = 1'b1; req = 1'b0; hit = 1'b0; ack = 1'b0; adr = '0;
    req2 = 1'b0; hit2 = 1'b0; ack2 = 1'b0; adr2 = '0;
    repeat (3) tick;
    grst = 1'b0;
    tick;

    chk("reset cyc", {31'd0, cyc}, 32'd0);
    chk("reset stb", {31'd0, stb}, 32'd0);
    chk("reset fill", {31'd0, fill}, 32'd0);
    chk("reset adr", {2'b00, adrO}, 32'd0);
    chk("reset cti", {29'd0, cti}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("sel", {28'd0, sel}, 32'hF);
    chk("wre", {31'd0, wre}, 32'd0);
    chk("bte wrap16", {30'd0, bte}, 32'd3);

    doFill(30'h45, 0, -1);
    doFill(30'h45, 2, -1);
    doFill(30'h123F, 0, -1);
    doFill(30'h2A, 0, 7);
    doFill(30'h83, 1, -1);

    req = 1'b1; hit = 1'b1; adr = 30'h99; ack = 1'b1;
    repeat (3) begin
      tick;
      chk("hit no cyc", {31'd0, cyc}, 32'd0);
      chk("hit no stall", {31'd0, stall}, 32'd0);
    end
    req = 1'b0; ack = 1'b0;
    tick;

    for (int i = 0; i < 8; i++) begin
      doFill(30'($urandom), -1, -1);
      ack = 1'b1;
      tick;
      ack = 1'b0;
      chk("stray ack idle", {31'd0, cyc}, 32'd0);
    end

    w2 = 30'($urandom);
    req2 = 1'b1; hit2 = 1'b0; adr2 = w2;
    n0 = cycNum;
    #1 chk("v1 miss stall", {31'd0, stall2}, 32'd1);
    tick;
    hit2 = 1'b1;
    chk("v1 cyc", {31'd0, cyc2}, 32'd1);
    chk("v1 adr", {2'b00, adrO2}, {2'b00, w2});
    chk("v1 cti", {29'd0, cti2}, 32'd7);
    chk("v1 bte", {30'd0, bte2}, 32'd0);
    ack2 = 1'b1;
    tick;
    ack2 = 1'b0;
    chk("v1 settle cyc", {31'd0, cyc2}, 32'd0);
    chk("v1 settle stall", {31'd0, stall2}, 32'd1);
    tick;
    chk("v1 release", {31'd0, stall2}, 32'd0);
    chk("v1 latency", cycNum - n0, 32'd3);
    req2 = 1'b0; hit2 = 1'b0;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aemb2_iwbm.md
# aemb2_iwbm

Instruction Wishbone bus master and cache line refill engine for the AEMB2 core. It sits between the instruction cache and the instruction Wishbone bus. When the fetch stage presents a valid address that misses the cache, the block stalls the pipeline. It then runs a critical-word-first wrapping burst that fetches the whole cache line, and releases the pipeline once the missed word can be read from the cache. The cache writes each returned beat itself, on `iwb_ack_i` and `iwb_dat_i`. This block only drives the address and control side of the bus.

## Interface

Parameters:
- `AEMB_IWB`, default 32: instruction bus address width in bits.
- `AEMB_IDX`, default 6: line index boundary; must match the cache.
  - LNE = AEMB_IDX-2.
  - Line length VAL = 2^LNE words.
  - Legal AEMB_IDX range is 2..6, so VAL is 1..16 words.

Ports:
- `gclk` in 1: system clock. Everything is clocked on its rising edge.
- `grst` in 1: system reset, synchronous, active-high.
- `ich_req` in 1: fetch stage is presenting a valid address on `ich_adr`.
- `ich_adr` in [AEMB_IWB-1:2]: fetch word address.
- `ich_hit` in 1: cache hit for `ich_adr`.
- `iwb_ack_i` in 1: Wishbone acknowledge. One ack equals one data beat.
- `iwb_adr_o` out [AEMB_IWB-1:2]: Wishbone word address.
- `iwb_cyc_o` out 1: Wishbone cycle.
- `iwb_stb_o` out 1: Wishbone strobe.
- `iwb_sel_o` out 4: byte selects, constant 4'hF.
- `iwb_wre_o` out 1: write enable, constant 0.
- `iwb_cti_o` out 3: cycle type.
  - 3'b010 = incrementing burst.
  - 3'b111 = last beat.
- `iwb_bte_o` out 2: burst wrap type. Constant per LNE:
  - LNE 0 or 1 → 2'b00
  - LNE 2 → 2'b01 (wrap-4)
  - LNE 3 → 2'b10 (wrap-8)
  - LNE 4 → 2'b11 (wrap-16)
- `ich_fill` out 1: line fill in progress. The top level steers the cache address to `iwb_adr_o` while this is high.
- `ich_stall` out 1: hold the pipeline (iena low).

## Operation

State machine states:
- **IDLE**
  - Miss condition = `ich_req & ~ich_hit`.
  - On a miss: latch base = `ich_adr[AEMB_IWB-1:AEMB_IDX]` and offset = `ich_adr[AEMB_IDX-1:2]`, clear the beat counter, go to FILL.
  - Otherwise stay in IDLE.
- **FILL**
  - `iwb_cyc_o = iwb_stb_o = 1`, `ich_fill = 1`.
  - `iwb_adr_o = {base, offset}`.
  - On each `iwb_ack_i`: offset ← offset+1 modulo VAL (wraps inside the line, base never changes) and count ← count+1.
  - The ack on beat VAL-1 (the last beat) moves to SETTLE.
  - Without an ack, all outputs hold; Wishbone classic rules apply (stb stays high until acked).
- **SETTLE**
  - Lasts one cycle. Bus idle, `ich_fill = 0`, `ich_stall = 1`.
  - The cache re-reads the original `ich_adr` and now hits.
  - Always goes to IDLE.

Output rules:
- `ich_stall = (state != IDLE) | (ich_req & ~ich_hit)`. This is combinational so the miss cycle itself is stalled.
- `iwb_cti_o`:
  - 3'b111 when count == VAL-1.
  - Otherwise 3'b010 while in FILL.
  - 3'b000 when not in FILL.
- When VAL = 1, the fill is a single beat with cti 3'b111.
- The beat counter is LNE+1 bits wide so it never overflows. The offset is exactly LNE bits and wraps naturally.
- `iwb_adr_o`, `iwb_cti_o` and `iwb_cyc_o`/`iwb_stb_o` are registered outputs, free of glitches.
- `ich_adr` and `ich_hit` are ignored outside IDLE. The pipeline is stalled then, so `ich_adr` is stable.
- `iwb_ack_i` is ignored outside FILL. Stray acks change no state.

## Timing

- Reset: `grst` sampled high puts the block in IDLE the next cycle. From then until the first miss:
  - `iwb_cyc_o = iwb_stb_o = 0`, `iwb_adr_o = 0`, `iwb_cti_o = 0`, `ich_fill = 0`.
  - `ich_stall` follows the combinational equation only.
- Reset mid-burst: `cyc`/`stb` drop in the cycle after `grst` is sampled. The partial line stays in the cache; its validity is the cache's responsibility.
- Miss sampled in cycle N → `cyc`/`stb` high with the critical word address in cycle N+1.
- With zero wait states the acks fall in cycles N+1..N+VAL.
- SETTLE falls in cycle N+VAL+1, and `ich_stall` is low in cycle N+VAL+2.
- Miss-to-release latency is VAL+2 cycles plus the total wait states.
- Back-to-back: a new miss can be accepted in the first IDLE cycle after SETTLE.

## Test plan

1. Reset with VAL=16 and no request → `cyc`, `stb`, `ich_fill` = 0, `iwb_sel_o` = F, `iwb_bte_o` = 2'b11.
2. Miss at address 0x0000_0114 (word 0x45, offset 5), acked every cycle → `iwb_adr_o` words 0x45..0x4F then 0x40..0x44. `iwb_cti_o` = 010 for 15 beats, then 111. `ich_stall` clears 18 cycles after the miss.
3. Same miss with 2 wait states per beat → each address held 3 cycles, exactly 16 acks accepted, release at 50 cycles.
4. Miss at offset 15 → first address word xF, second beat wraps to word x0, base unchanged.
5. Assert `grst` on beat 7 of a fill → `cyc`/`stb` = 0 next cycle. A later miss restarts cleanly at its own offset.
6. Hit with `ich_req=1`, and a stray ack in IDLE → no bus cycle, `ich_stall = 0`. Separately, with AEMB_IDX=2: a miss gives one beat with cti 111, bte 00, release 3 cycles later.
